bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning consecutive accesses one master may hold before yielding to a waiting master (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports m0_req_i / m1_req_i  input  1  access request from master 0 / 1.
REQ-005 The block SHALL have ports m0_addr_i / m1_addr_i  input  32  byte address.
REQ-006 The block SHALL have ports m0_we_i / m1_we_i  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports m0_wr_mask_i / m1_wr_mask_i  input  4  byte-lane write mask.
REQ-008 The block SHALL have ports m0_data_i / m1_data_i  input  32  write data.
REQ-009 The block SHALL have ports m0_gnt_o / m1_gnt_o  output  1  request consumed this cycle.
REQ-010 The block SHALL have ports m0_ack_o / m1_ack_o  output  1  access complete; read data valid.
REQ-011 The block SHALL have ports m0_data_o / m1_data_o  output  32  read data.
REQ-012 The block SHALL have ports s_addr_o  output  32, s_we_o  output  1, s_wr_mask_o  output  4, s_data_o  output  32  shared-bus slave request.
REQ-013 The block SHALL have port s_data_i  input  32  slave read data, valid one cycle after the address cycle (synchronous-read memory).
REQ-014 The block SHALL have port owner_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, DATA.
REQ-016 IDLE: if any request is high, the block SHALL latch the owner and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-017 Owner selection in IDLE and DATA SHALL use these rules.
  - Only one request high: that master is selected.
  - Both high: the master other than last_owner is selected.
  - last_owner resets to m1, so m0 wins the first tie.
REQ-018 ADDR SHALL last exactly one cycle with the following outputs.
  - s_addr_o, s_we_o, s_wr_mask_o and s_data_o driven combinationally from the owner's inputs.
  - Owner's gnt_o = 1.
  - Next state DATA.
REQ-019 In IDLE and DATA, s_we_o SHALL be 0 and s_addr_o, s_wr_mask_o and s_data_o SHALL be 0.
REQ-020 DATA SHALL last exactly one cycle with the following outputs.
  - Owner's ack_o = 1.
  - Owner's data_o = s_data_i.
  - The non-owner's data_o SHALL be 0.
REQ-021 Handshake rules:
  - A master holds req and its request fields stable from assertion until its gnt_o.
  - req high in the cycle after gnt_o (the DATA cycle) is a new request.
  - Read latency from gnt_o to ack_o is 1 cycle; a single access takes 2 cycles minimum, 3 from IDLE.
REQ-022 burst_cnt (4 bits) SHALL be incremented in each DATA cycle and SHALL be cleared when ownership changes or the FSM enters IDLE.
REQ-023 Next state from DATA:
  - Owner req high, and other req low or burst_cnt+1 < MAX_BURST: ADDR, same owner, back-to-back.
  - Else other req high: ADDR with the other owner, burst_cnt cleared.
  - Else: IDLE.
REQ-024 last_owner SHALL update to the owner on every ADDR cycle.
REQ-025 owner_o SHALL reflect the latched owner in ADDR and DATA and SHALL be 00 in IDLE.
REQ-026 A request that goes high during ADDR from the non-owner SHALL be held pending and SHALL NOT be dropped; it is evaluated in DATA.
REQ-027 With both masters requesting continuously, neither master SHALL get more than MAX_BURST consecutive accesses.
REQ-028 With MAX_BURST = 1, ownership SHALL alternate every access under contention.
REQ-029 At most one gnt_o and at most one ack_o SHALL be high in any cycle.

Reset
REQ-030 When reset_ni is low, the block SHALL immediately (asynchronously) apply the following reset state.
  - State IDLE, last_owner = m1, burst_cnt = 0.
  - All gnt_o, ack_o, data_o and s_* outputs = 0; owner_o = 00.
REQ-031 Reset asserted in ADDR or DATA SHALL abort the access with no ack_o; after release the FSM SHALL restart from IDLE.

Verification
REQ-032 Single read: m0 req, addr 0x10, with s_data_i = 0xDEADBEEF at the following cycle -> m0_gnt_o in cycle 2, m0_ack_o with m0_data_o = 0xDEADBEEF in cycle 3, then IDLE.
REQ-033 Write: m1 req, we = 1, mask 0x3, addr 0x1000, data 0x55 -> s_we_o = 1 for exactly one cycle carrying those values; m1_ack_o one cycle later.
REQ-034 Tie from reset: m0 and m1 req in the same cycle -> m0 granted first, then m1, then m0 (round-robin).
REQ-035 Fairness: MAX_BURST = 4, m0 req continuous and m1 req raised -> m0 gets at most 4 consecutive acks, then m1 is granted on the next ADDR.
REQ-036 Mid-access reset: reset_ni pulsed low during ADDR -> all outputs 0 immediately, no ack_o, owner_o = 00; a new m1 request after release is served normally.
REQ-037 Back-to-back: m0 req held 3 accesses, m1 idle -> gnt/ack alternate each cycle with no IDLE between them, owner_o = 01 throughout.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one synchronous-read slave bus.
// Each access is an ADDR cycle (grant) followed by a DATA cycle (ack), with burst capping.
module bus_arbiter_port (
  input  logic        i_own,
  input  logic        i_addr_st,
  input  logic        i_data_st,
  input  logic [31:0] i_s_data,
  output logic        o_gnt,
  output logic        o_ack,
  output logic [31:0] o_data
);
  assign o_gnt  = i_own & i_addr_st;
  assign o_ack  = i_own & i_data_st;
  assign o_data = o_ack ? i_s_data : 32'h0;
endmodule

module bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m1_data_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_wr_mask_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  output logic [1:0]  owner_o
);
  localparam int NM = 2;
  localparam logic [4:0] MAXB = 5'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic [3:0] r_burst_cnt;

  logic [NM-1:0]       w_req, w_we, w_gnt, w_ack;
  logic [NM-1:0][31:0] w_addr, w_wdata, w_rdata;
  logic [NM-1:0][3:0]  w_mask;
  logic                w_addr_st, w_data_st, w_own_req, w_oth_req, w_stay;
  logic [4:0]          w_cnt_inc;

  assign w_req   = {m1_req_i, m0_req_i};
  assign w_we    = {m1_we_i, m0_we_i};
  assign w_addr  = {m1_addr_i, m0_addr_i};
  assign w_wdata = {m1_data_i, m0_data_i};
  assign w_mask  = {m1_wr_mask_i, m0_wr_mask_i};

  // Ties go to the master that did not own the bus last.
  function automatic logic pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  assign w_addr_st = (r_state == ADDR);
  assign w_data_st = (r_state == DATA);
  assign w_own_req = w_req[r_owner];
  assign w_oth_req = w_req[~r_owner];
  assign w_cnt_inc = {1'b0, r_burst_cnt} + 5'd1;
  assign w_stay    = w_own_req & (~w_oth_req | (w_cnt_inc < MAXB));

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_burst_cnt <= 4'd0;
          if (|w_req) begin
            r_owner <= pick(w_req, r_last_owner);
            r_state <= ADDR;
          end
        end
        ADDR: begin
          r_last_owner <= r_owner;
          r_state      <= DATA;
        end
        DATA: begin
          if (w_stay) begin
            r_state <= ADDR;
            // Saturate so an uncontended stream never wraps back under the cap.
            if (r_burst_cnt != 4'hF) r_burst_cnt <= w_cnt_inc[3:0];
          end else if (w_oth_req) begin
            r_owner     <= ~r_owner;
            r_state     <= ADDR;
            r_burst_cnt <= 4'd0;
          end else begin
            r_state     <= IDLE;
            r_burst_cnt <= 4'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_addr_o    = w_addr_st ? w_addr[r_owner]  : 32'h0;
  assign s_we_o      = w_addr_st & w_we[r_owner];
  assign s_wr_mask_o = w_addr_st ? w_mask[r_owner]  : 4'h0;
  assign s_data_o    = w_addr_st ? w_wdata[r_owner] : 32'h0;
  assign owner_o     = (w_addr_st | w_data_st) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  for (genvar g = 0; g < NM; g++) begin : g_port
    bus_arbiter_port u_port (
      .i_own     (r_owner == 1'(g)),
      .i_addr_st (w_addr_st),
      .i_data_st (w_data_st),
      .i_s_data  (s_data_i),
      .o_gnt     (w_gnt[g]),
      .o_ack     (w_ack[g]),
      .o_data    (w_rdata[g])
    );
  end

  assign m0_gnt_o  = w_gnt[0];
  assign m1_gnt_o  = w_gnt[1];
  assign m0_ack_o  = w_ack[0];
  assign m1_ack_o  = w_ack[1];
  assign m0_data_o = w_rdata[0];
  assign m1_data_o = w_rdata[1];
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter: per-master request queues, expected acks
// queued in arbitration order and popped as the DUT acknowledges.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        m0_req_i = 0, m1_req_i = 0, m0_we_i = 0, m1_we_i = 0;
  logic [31:0] m0_addr_i = 0, m1_addr_i = 0, m0_data_i = 0, m1_data_i = 0;
  logic [3:0]  m0_wr_mask_i = 0, m1_wr_mask_i = 0;
  logic        m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, s_we_o;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic [31:0] s_data_i = 0;
  logic [3:0]  s_wr_mask_o;
  logic [1:0]  owner_o;

  bus_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset_ni(reset_ni),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_wr_mask_i(m0_wr_mask_i), .m1_wr_mask_i(m1_wr_mask_i),
    .m0_data_i(m0_data_i), .m1_data_i(m1_data_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_data_o(m0_data_o), .m1_data_o(m1_data_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wr_mask_o(s_wr_mask_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] mask; logic [31:0] data; } req_t;
  typedef struct { logic m; logic [31:0] d; } exp_t;

  req_t q0[$], q1[$];
  exp_t sb[$];
  exp_t mon_e;
  logic seen0 = 0, seen1 = 0;
  int   checks = 0, errors = 0;

  function automatic logic [31:0] slv(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ~a;
  endfunction

  // Synchronous-read slave: data for an address cycle appears the next cycle.
  always @(posedge clk) s_data_i <= slv(s_addr_o);

  always @(negedge clk) if (reset_ni) begin
    checks++;
    if ((m0_gnt_o && m1_gnt_o) || (m0_ack_o && m1_ack_o)) begin
      errors++;
      $display("FAIL exclusive: gnt=%b%b ack=%b%b, required at most one each",
               m1_gnt_o, m0_gnt_o, m1_ack_o, m0_ack_o);
    end
    if (m0_ack_o || m1_ack_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: m%0d acked at %0t, none expected", m1_ack_o, $time);
      end else begin
        mon_e = sb.pop_front();
        if (m1_ack_o !== mon_e.m || (m1_ack_o ? m1_data_o : m0_data_o) !== mon_e.d ||
            (m1_ack_o ? m0_data_o : m1_data_o) !== 32'h0) begin
          errors++;
          $display("FAIL ack: got m%0d data %h other %h, required m%0d data %h other 0",
                   m1_ack_o, m1_ack_o ? m1_data_o : m0_data_o,
                   m1_ack_o ? m0_data_o : m1_data_o, mon_e.m, mon_e.d);
        end
      end
    end
  end

  task automatic drive();
    if (seen0) begin void'(q0.pop_front()); seen0 = 0; end
    if (seen1) begin void'(q1.pop_front()); seen1 = 0; end
    if (q0.size() > 0) begin
      m0_req_i = 1; m0_addr_i = q0[0].addr; m0_we_i = q0[0].we;
      m0_wr_mask_i = q0[0].mask; m0_data_i = q0[0].data;
    end else begin
      m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_wr_mask_i = 0; m0_data_i = 0;
    end
    if (q1.size() > 0) begin
      m1_req_i = 1; m1_addr_i = q1[0].addr; m1_we_i = q1[0].we;
      m1_wr_mask_i = q1[0].mask; m1_data_i = q1[0].data;
    end else begin
      m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_wr_mask_i = 0; m1_data_i = 0;
    end
  endtask

  // One clock: note grants, then update master requests just after the edge.
  task automatic step();
    @(negedge clk);
    if (m0_gnt_o) seen0 = 1;
    if (m1_gnt_o) seen1 = 1;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic add(input logic m, input logic [31:0] a, input logic we,
                     input logic [3:0] mask, input logic [31:0] d);
    req_t r;
    r = '{a, we, mask, d};
    if (m) q1.push_back(r); else q0.push_back(r);
  endtask

  task automatic expect_ack(input logic m, input logic [31:0] a);
    exp_t e;
    e = '{m, slv(a)};
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin step(); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d acks outstanding, required 0", sb.size());
    end
    step(); step();
  endtask

  task automatic do_reset();
    reset_ni = 0;
    q0.delete(); q1.delete(); sb.delete();
    seen0 = 0; seen1 = 0;
    drive();
    @(posedge clk); #1;
    reset_ni = 1;
  endtask

  task automatic test_reset();
    #1;
    m0_req_i = 1; m1_req_i = 1;
    @(posedge clk); #1;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, m0_data_o, m1_data_o, s_addr_o,
         s_we_o, s_wr_mask_o, s_data_o, owner_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: owner=%b gnt=%b%b s_addr=%h, required all 0",
               owner_o, m1_gnt_o, m0_gnt_o, s_addr_o);
    end
    m0_req_i = 0; m1_req_i = 0;
    reset_ni = 1;
    step();
    checks++;
    if (owner_o !== 2'b00 || m0_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: owner=%b gnt0=%b, required 00/0", owner_o, m0_gnt_o);
    end
  endtask

  task automatic test_single_read();
    add(0, 32'h10, 0, 4'h0, 32'h0);
    expect_ack(0, 32'h10);
    step();
    checks++;
    if (m0_gnt_o !== 1'b0 || owner_o !== 2'b00) begin
      errors++;
      $display("FAIL read_c1: gnt=%b owner=%b, required 0/00", m0_gnt_o, owner_o);
    end
    step();
    checks++;
    if ({m0_gnt_o, s_addr_o, s_we_o, owner_o} !== {1'b1, 32'h10, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL read_c2: gnt=%b addr=%h we=%b owner=%b, required 1/10/0/01",
               m0_gnt_o, s_addr_o, s_we_o, owner_o);
    end
    step();
    checks++;
    if ({m0_ack_o, m0_data_o, m1_data_o} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL read_c3: ack=%b data=%h m1data=%h, required 1/deadbeef/0",
               m0_ack_o, m0_data_o, m1_data_o);
    end
    step();
    checks++;
    if (owner_o !== 2'b00 || m0_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: owner=%b ack=%b, required 00/0", owner_o, m0_ack_o);
    end
  endtask

  task automatic test_write();
    int nwe = 0, we_k = -1, ack_k = -1;
    add(1, 32'h1000, 1, 4'h3, 32'h55);
    expect_ack(1, 32'h1000);
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_we_o) begin
        nwe++; we_k = k;
        checks++;
        if ({s_addr_o, s_wr_mask_o, s_data_o, m1_gnt_o} !== {32'h1000, 4'h3, 32'h55, 1'b1}) begin
          errors++;
          $display("FAIL write_bus: addr=%h mask=%h data=%h gnt=%b, required 1000/3/55/1",
                   s_addr_o, s_wr_mask_o, s_data_o, m1_gnt_o);
        end
      end
      if (m1_ack_o) ack_k = k;
    end
    checks++;
    if (nwe != 1 || ack_k != we_k + 1) begin
      errors++;
      $display("FAIL write_timing: we cycles=%0d ack at %0d we at %0d, required 1 and ack=we+1",
               nwe, ack_k, we_k);
    end
  endtask

  task automatic test_tie();
    do_reset();
    add(0, 32'h400, 0, 0, 0); add(1, 32'h404, 0, 0, 0);
    expect_ack(0, 32'h400); expect_ack(1, 32'h404);
    drain();
    add(0, 32'h408, 0, 0, 0); add(1, 32'h40C, 0, 0, 0);
    expect_ack(0, 32'h408); expect_ack(1, 32'h40C);
    drain();
    add(0, 32'h410, 0, 0, 0);
    expect_ack(0, 32'h410);
    drain();
    add(0, 32'h414, 0, 0, 0); add(1, 32'h418, 0, 0, 0);
    expect_ack(1, 32'h418); expect_ack(0, 32'h414);
    drain();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 6; k++) add(0, 32'h100 + 32'(4 * k), 0, 0, 0);
    for (int k = 0; k < 4; k++) expect_ack(0, 32'h100 + 32'(4 * k));
    step(); step();
    add(1, 32'h200, 0, 0, 0);
    expect_ack(1, 32'h200);
    expect_ack(0, 32'h110); expect_ack(0, 32'h114);
    drain();
  endtask

  task automatic test_mid_reset();
    add(0, 32'h500, 0, 0, 0);
    step(); step();
    checks++;
    if (m0_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_addr: gnt=%b, required 1", m0_gnt_o);
    end
    #1 reset_ni = 0;
    #1;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, m0_data_o, m1_data_o, s_addr_o,
         s_we_o, s_wr_mask_o, s_data_o, owner_o} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: owner=%b gnt=%b s_addr=%h, required all 0",
               owner_o, m0_gnt_o, s_addr_o);
    end
    q0.delete(); seen0 = 0;
    drive();
    step(); step();
    reset_ni = 1;
    add(1, 32'h504, 0, 0, 0);
    expect_ack(1, 32'h504);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      add(0, 32'h300 + 32'(4 * k), 0, 0, 0);
      expect_ack(0, 32'h300 + 32'(4 * k));
    end
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (m0_gnt_o !== (k % 2 == 0) || m0_ack_o !== (k % 2 == 1) || owner_o !== 2'b01) begin
        errors++;
        $display("FAIL b2b_c%0d: gnt=%b ack=%b owner=%b, required %b/%b/01",
                 k, m0_gnt_o, m0_ack_o, owner_o, k % 2 == 0, k % 2 == 1);
      end
    end
    step();
    checks++;
    if (owner_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: owner=%b, required 00", owner_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_fairness();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
